stream_sel_mux: RTL and testbench

// - Parametrised N-channel, WIDTH-bit selector with valid/ready handshake per channel and one registered output.
// - Selection is either by an external sel index (MODE=0) or by round-robin arbitration (MODE=1).
// - Out-of-range sel grants nothing and raises an error pulse.
// - Sits between multiple producer streams and a single consumer, e.g. a shared datapath port.

---
 rtl/stream_sel_mux_pkg.sv | 12 +
 rtl/stream_sel_mux_rr_arbiter.sv | 31 +++
 rtl/stream_sel_mux.sv | 98 +++++++++
 tb/tb_stream_sel_mux.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/stream_sel_mux_pkg.sv
// Shared constants and helpers for stream_sel_mux and its round-robin arbiter.
package stream_sel_mux_pkg;

  localparam int MODE_SEL = 0;
  localparam int MODE_RR  = 1;

  // Index width that never collapses to zero bits.
  function automatic int sel_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/stream_sel_mux_rr_arbiter.sv
// Round-robin arbiter: searches upward from ptr+1, wrapping, for the first request.
module rr_arbiter
  import stream_sel_mux_pkg::*;
#(
  parameter int N_CH  = 6,
  parameter int SEL_W = sel_w(N_CH)
) (
  input  logic [N_CH-1:0]  req,
  input  logic [SEL_W-1:0] ptr,
  output logic [N_CH-1:0]  gnt_oh,
  output logic [SEL_W-1:0] gnt_idx,
  output logic             gnt_vld
);

  always_comb begin
    int idx;
    idx     = 0;
    gnt_oh  = '0;
    gnt_idx = '0;
    gnt_vld = 1'b0;
    for (int k = 1; k <= N_CH; k++) begin
      idx = (int'(ptr) + k) % N_CH;
      if (!gnt_vld && req[idx]) begin
        gnt_vld     = 1'b1;
        gnt_idx     = SEL_W'(idx);
        gnt_oh[idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/stream_sel_mux.sv
// N-channel valid/ready selector with one registered output stage, sel-driven or round-robin.
// Optional SEL_MUX_ERR_CNT_EN adds a saturating count of sel_err cycles on err_cnt.
module stream_sel_mux
  import stream_sel_mux_pkg::*;
#(
  parameter  int N_CH  = 6,
  parameter  int WIDTH = 4,
  parameter  int MODE  = MODE_SEL,
  localparam int SEL_W = sel_w(N_CH)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [SEL_W-1:0]      sel,
  input  logic [N_CH-1:0]       in_valid,
  output logic [N_CH-1:0]       in_ready,
  input  logic [N_CH*WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WIDTH-1:0]      out_data,
  output logic [SEL_W-1:0]      out_chan,
  output logic                  sel_err
`ifdef SEL_MUX_ERR_CNT_EN
  ,
  output logic [15:0]           err_cnt
`endif
);

  logic             load_en, xfer, sel_bad;
  logic [N_CH-1:0]  grant_oh;
  logic [SEL_W-1:0] grant;
  logic [WIDTH-1:0] mux_data;

  assign load_en = !out_valid || out_ready;
  assign sel_bad = int'(sel) >= N_CH;

  generate
    if (MODE == MODE_RR) begin : g_rr
      logic [SEL_W-1:0] rr_ptr;
      logic             unused_vld;

      rr_arbiter #(.N_CH(N_CH), .SEL_W(SEL_W)) u_arb (
        .req     (in_valid),
        .ptr     (rr_ptr),
        .gnt_oh  (grant_oh),
        .gnt_idx (grant),
        .gnt_vld (unused_vld)
      );

      // Pointer moves only on an accepted beat so a stalled winner keeps priority.
      always_ff @(posedge clk) begin
        if (reset)     rr_ptr <= SEL_W'(N_CH - 1);
        else if (xfer) rr_ptr <= grant;
      end
    end else begin : g_sel
      assign grant = sel;
      always_comb begin
        grant_oh = '0;
        for (int i = 0; i < N_CH; i++) grant_oh[i] = (sel == SEL_W'(i));
      end
    end
  endgenerate

  // Ready is held low while in reset so no producer sees a handshake then.
  assign in_ready = grant_oh & {N_CH{load_en && !reset}};
  assign xfer     = |(in_valid & in_ready);

  always_comb begin
    mux_data = '0;
    for (int i = 0; i < N_CH; i++)
      if (grant_oh[i]) mux_data = in_data[i*WIDTH +: WIDTH];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_chan  <= '0;
      sel_err   <= 1'b0;
    end else begin
      sel_err <= sel_bad && (MODE == MODE_SEL);
      if (xfer) begin
        out_valid <= 1'b1;
        out_data  <= mux_data;
        out_chan  <= grant;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

`ifdef SEL_MUX_ERR_CNT_EN
  always_ff @(posedge clk) begin
    if (reset)                           err_cnt <= '0;
    else if (sel_err && err_cnt != '1)   err_cnt <= err_cnt + 16'd1;
  end
`endif

endmodule

// File: tb/tb_stream_sel_mux.sv
// Directed bench: one sel-driven and one round-robin instance, checked with immediate assertions.
module tb_stream_sel_mux;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // sel-driven instance
  logic        rst0, out_ready0, out_valid0, sel_err0;
  logic [2:0]  sel0, out_chan0;
  logic [5:0]  in_valid0, in_ready0;
  logic [23:0] in_data0;
  logic [3:0]  out_data0;
`ifdef SEL_MUX_ERR_CNT_EN
  logic [15:0] err_cnt0, err_cnt1;
`endif

  // round-robin instance
  logic        rst1, out_ready1, out_valid1, sel_err1;
  logic [2:0]  sel1, out_chan1;
  logic [5:0]  in_valid1, in_ready1;
  logic [23:0] in_data1;
  logic [3:0]  out_data1;

  stream_sel_mux #(.N_CH(6), .WIDTH(4), .MODE(0)) u_sel (
    .clk(clk), .reset(rst0), .sel(sel0), .in_valid(in_valid0), .in_ready(in_ready0),
    .in_data(in_data0), .out_valid(out_valid0), .out_ready(out_ready0),
    .out_data(out_data0), .out_chan(out_chan0), .sel_err(sel_err0)
`ifdef SEL_MUX_ERR_CNT_EN
    , .err_cnt(err_cnt0)
`endif
  );

  stream_sel_mux #(.N_CH(6), .WIDTH(4), .MODE(1)) u_rr (
    .clk(clk), .reset(rst1), .sel(sel1), .in_valid(in_valid1), .in_ready(in_ready1),
    .in_data(in_data1), .out_valid(out_valid1), .out_ready(out_ready1),
    .out_data(out_data1), .out_chan(out_chan1), .sel_err(sel_err1)
`ifdef SEL_MUX_ERR_CNT_EN
    , .err_cnt(err_cnt1)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst0 = 1'b1; sel0 = 3'd0; in_valid0 = 6'h3F; in_data0 = '0; out_ready0 = 1'b1;
    rst1 = 1'b1; sel1 = 3'd7; in_valid1 = 6'h00; in_data1 = '0; out_ready1 = 1'b1;

    // reset with every channel valid
    tick();
    chk("rst_out_valid", out_valid0, 0);
    chk("rst_out_data",  out_data0,  0);
    chk("rst_out_chan",  out_chan0,  0);
    chk("rst_sel_err",   sel_err0,   0);
    chk("rst_in_ready",  in_ready0,  6'h00);
    tick();

    // select channel 3
    rst0 = 1'b0; sel0 = 3'd3; in_valid0 = 6'b001000; in_data0[12 +: 4] = 4'hA;
    #1 chk("sel3_in_ready", in_ready0, 6'b001000);
    tick();
    chk("sel3_out_valid", out_valid0, 1);
    chk("sel3_out_data",  out_data0,  4'hA);
    chk("sel3_out_chan",  out_chan0,  3);

    // stall: change sel and data3, held beat must not move
    out_ready0 = 1'b0; sel0 = 3'd1; in_valid0 = 6'b001010; in_data0[12 +: 4] = 4'h5;
    #1 chk("stall_in_ready", in_ready0, 6'h00);
    for (int k = 0; k < 2; k++) begin
      tick();
      chk("stall_out_valid", out_valid0, 1);
      chk("stall_out_data",  out_data0,  4'hA);
      chk("stall_out_chan",  out_chan0,  3);
    end

    // drain with no requester on selected channel
    out_ready0 = 1'b1; in_valid0 = 6'h00;
    #1 chk("drain_in_ready", in_ready0, 6'b000010);
    tick();
    chk("drain_out_valid", out_valid0, 0);
    chk("drain_out_data",  out_data0,  4'hA);
    chk("drain_out_chan",  out_chan0,  3);

    // back-to-back beats: drain and load in the same cycle
    sel0 = 3'd1; in_valid0 = 6'b000010; in_data0[4 +: 4] = 4'h7;
    tick();
    chk("b2b1_out_data", out_data0, 4'h7);
    chk("b2b1_out_chan", out_chan0, 1);
    sel0 = 3'd4; in_valid0 = 6'b010000; in_data0[16 +: 4] = 4'hC;
    #1 chk("b2b2_in_ready", in_ready0, 6'b010000);
    tick();
    chk("b2b2_out_valid", out_valid0, 1);
    chk("b2b2_out_data",  out_data0,  4'hC);
    chk("b2b2_out_chan",  out_chan0,  4);

    // out-of-range sel for three cycles
    in_valid0 = 6'h3F;
    sel0 = 3'd6;
    #1 chk("range_in_ready", in_ready0, 6'h00);
    tick();
    chk("range_err1", sel_err0, 1);
    chk("range_valid1", out_valid0, 0);
    sel0 = 3'd7;
    #1 chk("range7_in_ready", in_ready0, 6'h00);
    tick();
    chk("range_err2", sel_err0, 1);
    sel0 = 3'd6;
    tick();
    chk("range_err3", sel_err0, 1);
    chk("range_valid3", out_valid0, 0);
    sel0 = 3'd0; in_valid0 = 6'h00;
    tick();
    chk("range_err_clear", sel_err0, 0);
`ifdef SEL_MUX_ERR_CNT_EN
    tick();
    chk("range_err_cnt", err_cnt0, 3);
`endif

    // round-robin: all channels valid, sel ignored
    in_valid1 = 6'h3F;
    for (int i = 0; i < 6; i++) in_data1[i*4 +: 4] = 4'(i + 8);
    tick();
    chk("rr_rst_out_valid", out_valid1, 0);
    rst1 = 1'b0;
    #1 chk("rr_first_in_ready", in_ready1, 6'b000001);
    for (int k = 0; k < 7; k++) begin
      tick();
      chk("rr_full_out_valid", out_valid1, 1);
      chk("rr_full_out_chan",  out_chan1,  k % 6);
    end
    chk("rr_sel_err", sel_err1, 0);
    chk("rr_data_last", out_data1, 4'h8);

    // sparse requesters 2 and 5, reset mid-sequence
    rst1 = 1'b1; in_valid1 = 6'b100100;
    tick();
    rst1 = 1'b0;
    tick();
    chk("rr_sparse_c0", out_chan1, 2);
    tick();
    chk("rr_sparse_c1", out_chan1, 5);
    chk("rr_sparse_d1", out_data1, 4'hD);
    tick();
    chk("rr_sparse_c2", out_chan1, 2);
    tick();
    chk("rr_sparse_c3", out_chan1, 5);
    rst1 = 1'b1;
    tick();
    chk("rr_midrst_valid", out_valid1, 0);
    chk("rr_midrst_chan",  out_chan1,  0);
    rst1 = 1'b0;
    tick();
    chk("rr_after_rst_c0", out_chan1, 2);
    tick();
    chk("rr_after_rst_c1", out_chan1, 5);

    // single requester wins every cycle
    in_valid1 = 6'b001000;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("rr_single_chan",  out_chan1,  3);
      chk("rr_single_valid", out_valid1, 1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
